// File: rtl/sipo_pkg.sv
// Shared types for the SIPO frame receiver.
// Holds the FSM state enum and the default word width.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/sipo_shift_stage.sv
// Shift register and bit counter for the SIPO receiver.
// Ports: clk, i_rst_n (sync, active-low), i_sin serial bit,
//   i_restart (bit 0 of new frame), i_shift, i_cnt_clr,
//   o_word (assembled word), o_bit_cnt.
module sipo_shift_stage #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PAR_EN    = 1'b0,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_sin,
  input  logic             i_restart,
  input  logic             i_shift,
  input  logic             i_cnt_clr,
  output logic [WIDTH-1:0] o_word,
  output logic [CW-1:0]    o_bit_cnt
);

  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_first;

  assign w_shifted = MSB_FIRST ?
    {r_sreg[WIDTH-2:0], i_sin} :
    {i_sin, r_sreg[WIDTH-1:1]};

  // A restart shifts into an all-zero register.
  assign w_first = MSB_FIRST ?
    {{(WIDTH-1){1'b0}}, i_sin} :
    {i_sin, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_restart) begin
      r_sreg <= w_first;
      r_cnt  <= CW'(1);
    end else if (i_shift) begin
      r_sreg <= w_shifted;
      r_cnt  <= i_cnt_clr ? '0 : r_cnt + CW'(1);
    end else if (i_cnt_clr) begin
      r_cnt  <= '0;
    end
  end

  // With parity the word is complete in sreg before the
  // parity bit arrives; without it the last data bit is
  // still in flight, so the shifted value is the word.
  assign o_word    = PAR_EN ? r_sreg : w_shifted;
  assign o_bit_cnt = r_cnt;

endmodule

// File: rtl/sipo_frame_receiver.sv
// SIPO frame receiver: FSM, holding register, overrun, parity.
// Ports: clk, reset (sync, active-low), sin/sin_valid/sync in,
//   dout/dout_valid/dout_ready out port, overrun/ovr_clr,
//   parity_err. Macro SIPO_PARITY_EN adds an even-parity bit.
module sipo_frame_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_ovr;

  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    w_cnt;
  logic             w_restart;
  logic             w_accept;
  logic             w_in_shift;
  logic             w_last_data;
  logic             w_complete;
  logic             w_free;

  assign w_restart   = sin_valid & sync;
  assign w_accept    = sin_valid & ~sync &
                       (r_state != IDLE);
  assign w_in_shift  = w_accept & (r_state == SHIFT);
  assign w_last_data = w_in_shift &
                       (w_cnt == CW'(WIDTH - 1));
  assign w_free      = ~r_valid | dout_ready;

`ifdef SIPO_PARITY_EN
  logic r_perr;
  logic w_perr;
  assign w_complete = w_accept & (r_state == PARITY);
  assign w_perr     = ^{w_word, sin};
`else
  assign w_complete = w_last_data;
`endif

  sipo_shift_stage #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .PAR_EN    (PAR_EN),
    .CW        (CW)
  ) u_shift (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_sin     (sin),
    .i_restart (w_restart),
    .i_shift   (w_in_shift),
    .i_cnt_clr (w_complete),
    .o_word    (w_word),
    .o_bit_cnt (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      if (w_restart) begin
        r_state <= SHIFT;
`ifdef SIPO_PARITY_EN
      end else if (w_last_data) begin
        r_state <= PARITY;
      end else if (w_complete) begin
        r_state <= SHIFT;
`endif
      end

      if (w_complete && w_free) begin
        r_dout  <= w_word;
        r_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
        r_perr  <= w_perr;
`endif
      end else if (dout_ready) begin
        r_valid <= 1'b0;
      end

      // A drop on the clear edge wins.
      if (ovr_clr)
        r_ovr <= 1'b0;
      if (w_complete && !w_free)
        r_ovr <= 1'b1;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_ovr;
`ifdef SIPO_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Bench for sipo_frame_receiver: MSB-first and LSB-first
// instances driven by the same stream, directed plus random.
module tb_sipo_frame_receiver;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, sin, sin_valid, sync;
  logic dout_ready, ovr_clr;
  logic [W-1:0] dout, dout_l;
  logic dout_valid, dv_l;
  logic overrun, ovr_l;
  logic parity_err, perr_l;

  always #5 clk = ~clk;

  sipo_frame_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .sin(sin),
    .sin_valid(sin_valid), .sync(sync),
    .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .overrun(overrun),
    .ovr_clr(ovr_clr), .parity_err(parity_err)
  );

  sipo_frame_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .sin(sin),
    .sin_valid(sin_valid), .sync(sync),
    .dout(dout_l), .dout_valid(dv_l),
    .dout_ready(dout_ready), .overrun(ovr_l),
    .ovr_clr(ovr_clr), .parity_err(perr_l)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] expl_q[$];
  logic         expp_q[$];

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [W-1:0] e, el;
    logic ep;
    @(posedge clk);
    #1;
    if (mon_en && dout_valid) begin
      chk("word_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        el = expl_q.pop_front();
        ep = expp_q.pop_front();
        chk("rnd_dout_m", 32'(dout), 32'(e));
        chk("rnd_valid_l", 32'(dv_l), 32'd1);
        chk("rnd_dout_l", 32'(dout_l), 32'(el));
        chk("rnd_perr", 32'(parity_err), 32'(ep));
      end
    end
  endtask

  task automatic bitc(input logic b, input logic v,
                      input logic s);
    sin = b; sin_valid = v; sync = s;
    tick();
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++)
      bitc(1'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic send_word(input logic [W-1:0] w,
                           input bit s,
                           input int maxgap,
                           input logic pb,
                           input bit rdy_last);
    if (mon_en) begin
      exp_q.push_back(w);
      expl_q.push_back(rev(w));
      expp_q.push_back(PAR ? ((^w) ^ pb) : 1'b0);
    end
    for (int i = 0; i < W; i++) begin
      gap(int'($urandom_range(maxgap, 0)));
      if (rdy_last && i == W-1 && !PAR) dout_ready = 1'b1;
      bitc(w[W-1-i], 1'b1, s && i == 0);
    end
`ifdef SIPO_PARITY_EN
    gap(int'($urandom_range(maxgap, 0)));
    if (rdy_last) dout_ready = 1'b1;
    bitc(pb, 1'b1, 1'b0);
`endif
    sin_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, 32'({dout, dout_l}), 32'd0);
    chk({tag, "_valid"}, 32'({dout_valid, dv_l}), 32'd0);
    chk({tag, "_ovr"}, 32'({overrun, ovr_l}), 32'd0);
    chk({tag, "_perr"}, 32'({parity_err, perr_l}), 32'd0);
  endtask

  logic [W-1:0] rw;

  initial begin
    reset = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    sync = 1'b0; dout_ready = 1'b1; ovr_clr = 1'b0;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b1;

    // 1: A5, one-cycle valid
    send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    chk("t1_valid", 32'(dout_valid), 32'd1);
    chk("t1_dout", 32'(dout), 32'hA5);
    chk("t1_dout_l", 32'(dout_l), 32'(rev(8'hA5)));
    bitc(1'b0, 1'b0, 1'b0);
    chk("t1_valid_drop", 32'(dout_valid), 32'd0);

    // 2: stall, overrun, clear
    dout_ready = 1'b0;
    send_word(8'h3C, 1'b1, 0, 1'b0, 1'b0);
    chk("t2_first", 32'(dout), 32'h3C);
    chk("t2_ovr0", 32'(overrun), 32'd0);
    send_word(8'hC3, 1'b0, 0, 1'b1, 1'b0);
    chk("t2_hold", 32'(dout), 32'h3C);
    chk("t2_valid", 32'(dout_valid), 32'd1);
    chk("t2_ovr1", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    bitc(1'b0, 1'b0, 1'b0);
    ovr_clr = 1'b0;
    chk("t2_ovr_clr", 32'(overrun), 32'd0);
    chk("t2_hold2", 32'(dout), 32'h3C);
    dout_ready = 1'b1;
    bitc(1'b0, 1'b0, 1'b0);
    chk("t2_consumed", 32'(dout_valid), 32'd0);

    // 3: resync discards partial word
    bitc(1'b1, 1'b1, 1'b1);
    bitc(1'b0, 1'b1, 1'b0);
    bitc(1'b1, 1'b1, 1'b0);
    chk("t3_no_partial", 32'(dout_valid), 32'd0);
    send_word(8'h5A, 1'b1, 0, 1'b0, 1'b0);
    chk("t3_dout", 32'(dout), 32'h5A);
    chk("t3_valid", 32'(dout_valid), 32'd1);
    bitc(1'b0, 1'b0, 1'b0);
    chk("t3_single", 32'(dout_valid), 32'd0);

    // 4: completion on handshake edge
    dout_ready = 1'b0;
    send_word(8'h11, 1'b1, 0, 1'b0, 1'b0);
    chk("t4_first", 32'(dout), 32'h11);
    send_word(8'h22, 1'b0, 0, 1'b0, 1'b1);
    chk("t4_dout", 32'(dout), 32'h22);
    chk("t4_valid", 32'(dout_valid), 32'd1);
    chk("t4_ovr", 32'(overrun), 32'd0);
    bitc(1'b0, 1'b0, 1'b0);
    chk("t4_consumed", 32'(dout_valid), 32'd0);

    // 5: gaps, LSB-first, mid-frame reset
    send_word(8'hF0, 1'b1, 3, 1'b0, 1'b0);
    chk("t5_msb", 32'(dout), 32'hF0);
    chk("t5_lsb", 32'(dout_l), 32'h0F);
    dout_ready = 1'b0;
    send_word(8'h77, 1'b0, 2, 1'b1, 1'b0);
    send_word(8'h88, 1'b0, 2, 1'b0, 1'b0);
    chk("t5_pre_ovr", 32'(overrun), 32'd1);
    bitc(1'b1, 1'b1, 1'b1);
    bitc(1'b1, 1'b1, 1'b0);
    bitc(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    bitc(1'b0, 1'b0, 1'b0);
    chk_zero("t5_rst");
    reset = 1'b1;
    dout_ready = 1'b1;
    send_word(8'hFF, 1'b0, 1, 1'b0, 1'b0);
    chk("t5_idle_ignored", 32'(dout_valid), 32'd0);
    bitc(1'b0, 1'b0, 1'b0);
    chk("t5_idle_ignored2", 32'(dout_valid), 32'd0);
    send_word(8'hC3, 1'b1, 1, 1'b0, 1'b0);
    chk("t5_after_rst", 32'(dout), 32'hC3);
    chk("t5_after_rst_l", 32'(dout_l), 32'(rev(8'hC3)));
    bitc(1'b0, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
    // 6: even parity
    send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    chk("t6_dout0", 32'(dout), 32'hA5);
    chk("t6_perr0", 32'(parity_err), 32'd0);
    send_word(8'hA5, 1'b0, 0, 1'b1, 1'b0);
    chk("t6_dout1", 32'(dout), 32'hA5);
    chk("t6_perr1", 32'(parity_err), 32'd1);
    chk("t6_perr1_l", 32'(perr_l), 32'd1);
    bitc(1'b0, 1'b0, 1'b0);
`else
    send_word(8'h01, 1'b1, 0, 1'b1, 1'b0);
    chk("t6_perr_tied", 32'(parity_err), 32'd0);
    bitc(1'b0, 1'b0, 1'b0);
`endif

    // random frames against the queue model
    mon_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rw = W'($urandom);
      send_word(rw, (n == 0) || 1'($urandom), 3,
                1'($urandom), 1'b0);
    end
    gap(3);
    mon_en = 1'b0;
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_no_ovr", 32'({overrun, ovr_l}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
